// File: rtl/machine_arbiter_if.sv
// Signal bundle for machine_arbiter: per-client request/strobe lines and the shared SRAM/UART pin outputs.
// master = arbiter side, slave = board/client side. ram_data stays a plain inout on the arbiter.
interface machine_arbiter_if #(
  parameter int unsigned N_CLIENTS = 2,
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned SEL_W     = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
);
  logic [N_CLIENTS*ADDR_W-1:0] cl_addr;
  logic [N_CLIENTS*DATA_W-1:0] cl_wdata;
  logic [N_CLIENTS-1:0]        cl_dout_en;
  logic [N_CLIENTS-1:0]        cl_oe_n;
  logic [N_CLIENTS-1:0]        cl_we_n;
  logic [N_CLIENTS-1:0]        cl_en_n;
  logic [N_CLIENTS-1:0]        cl_rdn;
  logic [N_CLIENTS-1:0]        cl_wrn;
  logic [N_CLIENTS-1:0]        cl_busy;
  logic [N_CLIENTS-1:0]        cl_enable;
  logic [N_CLIENTS-1:0]        cl_yield;
  logic [DATA_W-1:0]           cl_rdata;
  logic [ADDR_W-1:0]           ram_addr;
  logic                        ram_oe_n;
  logic                        ram_we_n;
  logic                        ram_en_n;
  logic                        rdn;
  logic                        wrn;
  logic [SEL_W-1:0]            sel;
  logic                        switching;

  modport master (
    input  cl_addr, cl_wdata, cl_dout_en, cl_oe_n, cl_we_n, cl_en_n, cl_rdn, cl_wrn, cl_busy,
    output cl_enable, cl_yield, cl_rdata, ram_addr, ram_oe_n, ram_we_n, ram_en_n, rdn, wrn,
           sel, switching
  );

  modport slave (
    output cl_addr, cl_wdata, cl_dout_en, cl_oe_n, cl_we_n, cl_en_n, cl_rdn, cl_wrn, cl_busy,
    input  cl_enable, cl_yield, cl_rdata, ram_addr, ram_oe_n, ram_we_n, ram_en_n, rdn, wrn,
           sel, switching
  );
endinterface

// File: rtl/machine_arbiter.sv
// Round-robin owner switch for N client machines sharing one SRAM port and the UART strobes.
// Optional SWITCH_TIMEOUT_EN: forced handover after a drain timeout, plus sticky timeout_flag output.
module machine_arbiter #(
  parameter int unsigned N_CLIENTS       = 2,
  parameter int unsigned ADDR_W          = 18,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned GUARD_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key,
`ifdef SWITCH_TIMEOUT_EN
  output logic                timeout_flag,
`endif
  inout  wire  [DATA_W-1:0]   ram_data,
  machine_arbiter_if.master   bus
);

  localparam int unsigned SEL_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned GD_W  = $clog2(GUARD_CYCLES + 1);

  localparam logic [1:0] OWN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] GUARD = 2'd2;

  localparam logic [N_CLIENTS-1:0] LSB_ONE = {{(N_CLIENTS-1){1'b0}}, 1'b1};

  // ---------------- key debounce ----------------
  logic [DB_W-1:0] tick_cnt;
  logic            tick;
  logic [3:0]      key_hist;
  logic            key_stable;
  logic            stable_next;
  logic            press;

  assign tick = (tick_cnt == DB_W'(DEBOUNCE_CYCLES - 1));

  always_comb begin
    stable_next = key_stable;
    if (key_hist == 4'b0000)      stable_next = 1'b0;
    else if (key_hist == 4'b1111) stable_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt   <= '0;
      key_hist   <= '1;
      key_stable <= 1'b1;
      press      <= 1'b0;
    end else begin
      tick_cnt   <= tick ? '0 : tick_cnt + DB_W'(1);
      if (tick) key_hist <= {key_hist[2:0], key};
      key_stable <= stable_next;
      press      <= key_stable & ~stable_next;
    end
  end

  // ---------------- ownership FSM ----------------
  logic [1:0]           state;
  logic [SEL_W-1:0]     sel_q;
  logic [SEL_W-1:0]     sel_inc;
  logic [GD_W-1:0]      guard_cnt;
  logic [N_CLIENTS-1:0] enable_q;
  logic [N_CLIENTS-1:0] yield_q;
  logic                 owner_busy;
  logic                 drain_done;
  logic                 own_bus;

  assign owner_busy = bus.cl_busy[sel_q];
  assign sel_inc    = (sel_q == SEL_W'(N_CLIENTS - 1)) ? '0 : sel_q + SEL_W'(1);

`ifdef SWITCH_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] drain_cnt;
  logic            timed_out;
  logic            flag_q;

  assign timed_out  = (drain_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign drain_done = ~owner_busy | timed_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drain_cnt <= '0;
      flag_q    <= 1'b0;
    end else begin
      drain_cnt <= (state == DRAIN) ? drain_cnt + TO_W'(1) : '0;
      if (state == DRAIN && owner_busy && timed_out) flag_q <= 1'b1;
    end
  end

  assign timeout_flag = flag_q;
`else
  assign drain_done = ~owner_busy;
`endif

  // The DRAIN->GUARD edge already counts as the first idle cycle, so that entry preloads 1;
  // reset starts the count at 0, giving one extra idle cycle after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= GUARD;
      sel_q     <= '0;
      guard_cnt <= '0;
      enable_q  <= '0;
      yield_q   <= '0;
    end else begin
      case (state)
        OWN: begin
          if (press) begin
            state   <= DRAIN;
            yield_q <= LSB_ONE << sel_q;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state     <= GUARD;
            enable_q  <= '0;
            yield_q   <= '0;
            sel_q     <= sel_inc;
            guard_cnt <= GD_W'(1);
          end
        end
        GUARD: begin
          if (guard_cnt >= GD_W'(GUARD_CYCLES)) begin
            state     <= OWN;
            enable_q  <= LSB_ONE << sel_q;
            guard_cnt <= '0;
          end else begin
            guard_cnt <= guard_cnt + GD_W'(1);
          end
        end
        default: begin
          state    <= GUARD;
          enable_q <= '0;
          yield_q  <= '0;
        end
      endcase
    end
  end

  // ---------------- registered output mux ----------------
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              dout_en_q;
  logic              oe_n_q, we_n_q, en_n_q, rdn_q, wrn_q;

  // The pins go idle on the very edge that leaves DRAIN, not one cycle later.
  assign own_bus = (state == OWN) || (state == DRAIN && !drain_done);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      dout_en_q <= 1'b0;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      en_n_q    <= 1'b1;
      rdn_q     <= 1'b1;
      wrn_q     <= 1'b1;
    end else if (own_bus) begin
      addr_q    <= bus.cl_addr[sel_q*ADDR_W +: ADDR_W];
      wdata_q   <= bus.cl_wdata[sel_q*DATA_W +: DATA_W];
      dout_en_q <= bus.cl_dout_en[sel_q];
      oe_n_q    <= bus.cl_oe_n[sel_q];
      we_n_q    <= bus.cl_we_n[sel_q];
      en_n_q    <= bus.cl_en_n[sel_q];
      rdn_q     <= bus.cl_rdn[sel_q];
      wrn_q     <= bus.cl_wrn[sel_q];
    end else begin
      addr_q    <= '0;
      wdata_q   <= '0;
      dout_en_q <= 1'b0;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      en_n_q    <= 1'b1;
      rdn_q     <= 1'b1;
      wrn_q     <= 1'b1;
    end
  end

  assign ram_data      = dout_en_q ? wdata_q : 'z;
  assign bus.cl_rdata  = ram_data;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_oe_n  = oe_n_q;
  assign bus.ram_we_n  = we_n_q;
  assign bus.ram_en_n  = en_n_q;
  assign bus.rdn       = rdn_q;
  assign bus.wrn       = wrn_q;
  assign bus.cl_enable = enable_q;
  assign bus.cl_yield  = yield_q;
  assign bus.sel       = sel_q;
  assign bus.switching = (state != OWN);

endmodule

// File: tb/tb_machine_arbiter.sv
// Randomized self-checking bench for machine_arbiter (3 clients, short debounce/guard/timeout).
module tb_machine_arbiter;
  localparam int unsigned N  = 3;
  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;
  localparam int unsigned DB = 4;
  localparam int unsigned GC = 2;
  localparam int unsigned TO = 16;
  localparam int unsigned SW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key = 1'b1;
  wire  [DW-1:0] ram_data;
  logic tb_drv = 1'b1;
  logic [DW-1:0] tb_val = '0;
  assign ram_data = tb_drv ? tb_val : 'z;
`ifdef SWITCH_TIMEOUT_EN
  logic timeout_flag;
`endif

  machine_arbiter_if #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  machine_arbiter #(
    .N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW),
    .DEBOUNCE_CYCLES(DB), .GUARD_CYCLES(GC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .key(key),
`ifdef SWITCH_TIMEOUT_EN
    .timeout_flag(timeout_flag),
`endif
    .ram_data(ram_data), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned exp_sel = 0;

  logic [AW-1:0] c_addr  [N];
  logic [DW-1:0] c_wdata [N];
  logic [N-1:0]  c_dout_en, c_oe, c_we, c_en, c_rdn, c_wrn, c_busy;

  function automatic logic [N-1:0] onehot(input int unsigned s);
    logic [N-1:0] v;
    v = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  task automatic apply_clients();
    for (int i = 0; i < N; i++) begin
      bus.cl_addr[i*AW +: AW]  = c_addr[i];
      bus.cl_wdata[i*DW +: DW] = c_wdata[i];
    end
    bus.cl_dout_en = c_dout_en;
    bus.cl_oe_n    = c_oe;
    bus.cl_we_n    = c_we;
    bus.cl_en_n    = c_en;
    bus.cl_rdn     = c_rdn;
    bus.cl_wrn     = c_wrn;
    bus.cl_busy    = c_busy;
  endtask

  task automatic rand_clients();
    for (int i = 0; i < N; i++) begin
      c_addr[i]  = AW'($urandom);
      c_wdata[i] = DW'($urandom);
    end
    c_dout_en = N'($urandom);
    c_oe      = N'($urandom);
    c_we      = N'($urandom);
    c_en      = N'($urandom);
    c_rdn     = N'($urandom);
    c_wrn     = N'($urandom);
    apply_clients();
  endtask

  task automatic test_reset();
    rst = 1'b0; key = 1'b1; c_busy = '0;
    rand_clients();
    c_oe = '0; c_we = '0; c_en = '0; c_rdn = '0; c_wrn = '0; c_dout_en = '0;
    apply_clients();
    tb_drv = 1'b1; tb_val = '0;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.cl_enable !== 3'b000) begin n_fail++; $display("FAIL rst_enable: got %b expected 000", bus.cl_enable); end
    n_tests++; if (bus.cl_yield !== 3'b000) begin n_fail++; $display("FAIL rst_yield: got %b expected 000", bus.cl_yield); end
    n_tests++; if (bus.sel !== SW'(0) || bus.switching !== 1'b1) begin n_fail++; $display("FAIL rst_sel_sw: got sel=%0d sw=%b expected sel=0 sw=1", bus.sel, bus.switching); end
    n_tests++; if ({bus.ram_oe_n, bus.ram_we_n, bus.ram_en_n, bus.rdn, bus.wrn} !== 5'b11111 || bus.ram_addr !== '0)
      begin n_fail++; $display("FAIL rst_pins: got strobes=%b addr=%h expected 11111/0", {bus.ram_oe_n, bus.ram_we_n, bus.ram_en_n, bus.rdn, bus.wrn}, bus.ram_addr); end
    rst = 1'b1;
    for (int k = 0; k < GC + 1; k++) begin
      n_tests++; if (bus.cl_enable !== 3'b000) begin n_fail++; $display("FAIL rel_idle%0d: got %b expected 000", k, bus.cl_enable); end
      @(negedge clk);
    end
    n_tests++; if (bus.cl_enable !== 3'b001 || bus.sel !== SW'(0) || bus.switching !== 1'b0)
      begin n_fail++; $display("FAIL rel_own: got en=%b sel=%0d sw=%b expected 001/0/0", bus.cl_enable, bus.sel, bus.switching); end
    @(negedge clk);
    n_tests++; if (bus.ram_addr !== c_addr[0] || bus.ram_oe_n !== 1'b0)
      begin n_fail++; $display("FAIL rel_addr: got %h/%b expected %h/0", bus.ram_addr, bus.ram_oe_n, c_addr[0]); end
    exp_sel = 0;
  endtask

  task automatic test_bus_mux();
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [4:0]    es;
    for (int it = 0; it < 20; it++) begin
      rand_clients();
      tb_drv = ~c_dout_en[exp_sel];
      tb_val = DW'($urandom);
      ea = c_addr[exp_sel];
      ed = c_dout_en[exp_sel] ? c_wdata[exp_sel] : tb_val;
      es = {c_oe[exp_sel], c_we[exp_sel], c_en[exp_sel], c_rdn[exp_sel], c_wrn[exp_sel]};
      @(negedge clk);
      n_tests++; if (bus.ram_addr !== ea) begin n_fail++; $display("FAIL mux_addr: got %h expected %h", bus.ram_addr, ea); end
      n_tests++; if ({bus.ram_oe_n, bus.ram_we_n, bus.ram_en_n, bus.rdn, bus.wrn} !== es)
        begin n_fail++; $display("FAIL mux_strobes: got %b expected %b", {bus.ram_oe_n, bus.ram_we_n, bus.ram_en_n, bus.rdn, bus.wrn}, es); end
      n_tests++; if (bus.cl_rdata !== ed) begin n_fail++; $display("FAIL mux_data: got %h expected %h", bus.cl_rdata, ed); end
    end
  endtask

  task automatic test_press();
    int zeros = 0;
    for (int i = 0; i < N; i++) c_wdata[i] = 16'hA5C3;
    c_dout_en = '1; c_oe = '0; c_we = '0; c_en = '0; c_rdn = '0; c_wrn = '0; c_busy = '0;
    apply_clients();
    tb_drv = 1'b1; tb_val = '0;
    key = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (k == 40) key = 1'b1;
      @(negedge clk);
      if (bus.cl_enable === 3'b000) begin
        zeros++;
        n_tests++; if ({bus.ram_oe_n, bus.ram_we_n, bus.ram_en_n, bus.rdn, bus.wrn} !== 5'b11111 || bus.ram_addr !== '0 || bus.cl_rdata !== '0)
          begin n_fail++; $display("FAIL guard_idle: got strobes=%b addr=%h data=%h expected 11111/0/Z", {bus.ram_oe_n, bus.ram_we_n, bus.ram_en_n, bus.rdn, bus.wrn}, bus.ram_addr, bus.cl_rdata); end
      end
    end
    exp_sel = (exp_sel + 1) % N;
    n_tests++; if (zeros != GC) begin n_fail++; $display("FAIL press_gap: got %0d idle cycles expected %0d", zeros, GC); end
    n_tests++; if (bus.sel !== SW'(exp_sel) || bus.cl_enable !== onehot(exp_sel))
      begin n_fail++; $display("FAIL press_owner: got sel=%0d en=%b expected %0d/%b", bus.sel, bus.cl_enable, exp_sel, onehot(exp_sel)); end
    tb_drv = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.cl_rdata !== 16'hA5C3) begin n_fail++; $display("FAIL owner_drive: got %h expected a5c3", bus.cl_rdata); end
    tb_drv = 1'b1;
  endtask

  task automatic test_glitch();
    int unsigned len;
    logic moved;
    for (int it = 0; it < 3; it++) begin
      len = (it == 0) ? 8 : $urandom_range(1, 12);
      moved = 1'b0;
      key = 1'b0;
      for (int k = 0; k < 40; k++) begin
        if (k == len) key = 1'b1;
        @(negedge clk);
        if (bus.cl_enable !== onehot(exp_sel)) moved = 1'b1;
      end
      n_tests++; if (moved !== 1'b0 || bus.sel !== SW'(exp_sel))
        begin n_fail++; $display("FAIL glitch_%0d: got sel=%0d moved=%b expected sel=%0d moved=0", len, bus.sel, moved, exp_sel); end
    end
  endtask

  task automatic test_random_presses();
    logic is_press;
    logic multi;
    int unsigned lo, hi;
    for (int it = 0; it < 8; it++) begin
      rand_clients();
      c_busy = N'($urandom) & ~onehot(exp_sel);
      apply_clients();
      is_press = 1'($urandom_range(0, 1));
      lo = is_press ? $urandom_range(20, 40) : $urandom_range(1, 12);
      hi = $urandom_range(30, 40);
      multi = 1'b0;
      key = 1'b0;
      for (int k = 0; k < lo + hi; k++) begin
        if (k == lo) key = 1'b1;
        @(negedge clk);
        if ($countones(bus.cl_enable) > 1) multi = 1'b1;
      end
      if (is_press) exp_sel = (exp_sel + 1) % N;
      n_tests++; if (multi !== 1'b0) begin n_fail++; $display("FAIL onehot_%0d: got multiple enables expected at most one", it); end
      n_tests++; if (bus.sel !== SW'(exp_sel) || bus.cl_enable !== onehot(exp_sel))
        begin n_fail++; $display("FAIL rand_owner_%0d: got sel=%0d en=%b expected %0d/%b", it, bus.sel, bus.cl_enable, exp_sel, onehot(exp_sel)); end
    end
    c_busy = '0; apply_clients();
  endtask

  task automatic test_busy_drain();
    logic got = 1'b0;
    logic held = 1'b1;
    int unsigned b;
    c_busy = N'($urandom) | onehot(exp_sel);
    apply_clients();
    key = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (bus.cl_yield !== 3'b000) got = 1'b1;
    end
    key = 1'b1;
    n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL drain_wait: got no yield expected yield within 100 cycles"); end
    n_tests++; if (bus.cl_yield !== onehot(exp_sel) || bus.cl_enable !== onehot(exp_sel) || bus.switching !== 1'b1)
      begin n_fail++; $display("FAIL drain_state: got y=%b en=%b sw=%b expected %b/%b/1", bus.cl_yield, bus.cl_enable, bus.switching, onehot(exp_sel), onehot(exp_sel)); end
`ifndef SWITCH_TIMEOUT_EN
    for (int k = 0; k < 90; k++) begin
      key = (k >= 30 && k < 60) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (bus.cl_yield !== onehot(exp_sel)) held = 1'b0;
    end
`endif
    b = $urandom_range(1, 12);
    for (int k = 0; k < b; k++) begin
      @(negedge clk);
      if (bus.cl_yield !== onehot(exp_sel)) held = 1'b0;
    end
    n_tests++; if (held !== 1'b1) begin n_fail++; $display("FAIL drain_hold: got early exit expected DRAIN while busy"); end
    c_busy[exp_sel] = 1'b0;
    apply_clients();
    @(negedge clk);
    exp_sel = (exp_sel + 1) % N;
    n_tests++; if (bus.cl_yield !== 3'b000 || bus.cl_enable !== 3'b000 || bus.switching !== 1'b1 || bus.sel !== SW'(exp_sel))
      begin n_fail++; $display("FAIL drain_exit: got y=%b en=%b sw=%b sel=%0d expected 000/000/1/%0d", bus.cl_yield, bus.cl_enable, bus.switching, bus.sel, exp_sel); end
    c_busy = '0; apply_clients();
    repeat (GC) @(negedge clk);
    n_tests++; if (bus.cl_enable !== onehot(exp_sel)) begin n_fail++; $display("FAIL drain_next: got %b expected %b", bus.cl_enable, onehot(exp_sel)); end
    repeat (40) @(negedge clk);
    n_tests++; if (bus.sel !== SW'(exp_sel)) begin n_fail++; $display("FAIL drain_noqueue: got sel=%0d expected %0d", bus.sel, exp_sel); end
  endtask

  task automatic test_reset_mid_drain();
    logic got = 1'b0;
    c_busy = '1; apply_clients();
    key = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (bus.cl_yield !== 3'b000) got = 1'b1;
    end
    n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL mid_wait: got no yield expected yield within 100 cycles"); end
    rst = 1'b0; key = 1'b1;
    #1;
    n_tests++; if (bus.sel !== SW'(0) || bus.cl_enable !== 3'b000 || bus.cl_yield !== 3'b000 || bus.switching !== 1'b1)
      begin n_fail++; $display("FAIL mid_reset: got sel=%0d en=%b y=%b sw=%b expected 0/000/000/1", bus.sel, bus.cl_enable, bus.cl_yield, bus.switching); end
    @(negedge clk);
    c_busy = '0; apply_clients();
    rst = 1'b1;
    exp_sel = 0;
    repeat (GC + 1) @(negedge clk);
    n_tests++; if (bus.cl_enable !== 3'b001 || bus.sel !== SW'(0)) begin n_fail++; $display("FAIL mid_restart: got en=%b sel=%0d expected 001/0", bus.cl_enable, bus.sel); end
`ifdef SWITCH_TIMEOUT_EN
    n_tests++; if (timeout_flag !== 1'b0) begin n_fail++; $display("FAIL flag_reset: got %b expected 0", timeout_flag); end
`endif
  endtask

`ifdef SWITCH_TIMEOUT_EN
  task automatic test_timeout();
    logic got = 1'b0;
    int cnt = 0;
    c_busy = '1; apply_clients();
    key = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (bus.cl_yield !== 3'b000) got = 1'b1;
    end
    key = 1'b1;
    n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL to_wait: got no yield expected yield within 100 cycles"); end
    cnt = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.cl_yield === 3'b000) break;
      cnt++;
    end
    exp_sel = (exp_sel + 1) % N;
    n_tests++; if (cnt != TO) begin n_fail++; $display("FAIL to_len: got %0d drain cycles expected %0d", cnt, TO); end
    n_tests++; if (timeout_flag !== 1'b1 || bus.sel !== SW'(exp_sel)) begin n_fail++; $display("FAIL to_flag: got flag=%b sel=%0d expected 1/%0d", timeout_flag, bus.sel, exp_sel); end
    repeat (10) @(negedge clk);
    n_tests++; if (timeout_flag !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b expected 1", timeout_flag); end
  endtask
`endif

  initial begin
    c_busy = '0;
    rand_clients();
    test_reset();
    test_bus_mux();
    test_press();
    test_glitch();
    test_random_presses();
    test_busy_drain();
    test_reset_mid_drain();
`ifdef SWITCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog");
  end
endmodule
